cu_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the control-unit layer. It owns the architectural `state` register that every sub-control unit (immediate, register, memory, branch) decodes. It classifies the loaded IR, selects one sub-CU's control word and `k_mux`, and follows that unit's `NS` until the instruction retires. It also handles the fetch cycle, memory wait stalls, illegal opcodes, the runaway-sequence watchdog and halt.

---
 rtl/cu_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_cu_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cu_sequencer.sv
// cu_sequencer: multi-cycle control-unit sequencer. Owns the architectural
// state register, picks one sub-CU's control word / k_mux / next-state per
// instruction class, and handles fetch, memory stalls, illegal opcodes,
// the runaway-sequence watchdog and halt.
module cu_sequencer #(
    parameter int unsigned   CUL      = 35,
    parameter logic [CUL:0]  FETCH_CW = 36'h000001220,
    parameter logic [CUL:0]  NOP_CW   = 36'h000000001,
    parameter int unsigned   MAX_EXEC = 8
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic [31:0]    IR,
    input  logic           mem_ready,
    input  logic           halt_req,
    input  logic [CUL:0]   cw_imm,
    input  logic [CUL:0]   cw_reg,
    input  logic [CUL:0]   cw_mem,
    input  logic [CUL:0]   cw_br,
    input  logic [3:0]     ns_imm,
    input  logic [3:0]     ns_reg,
    input  logic [3:0]     ns_mem,
    input  logic [3:0]     ns_br,
    input  logic [2:0]     k_imm,
    input  logic [2:0]     k_reg,
    input  logic [2:0]     k_mem,
    input  logic [2:0]     k_br,
    output logic [3:0]     state,
    output logic [CUL:0]   controlWord,
    output logic [2:0]     k_mux,
    output logic           halted,
    output logic           illegal,
    output logic           timeout,
    output logic           retire
);

    typedef enum logic [1:0] {StFetch, StExec, StHalt} phase_e;
    typedef enum logic [2:0] {ClsImm, ClsReg, ClsMem, ClsBr, ClsIll} cls_e;

    localparam logic [3:0] MaxCnt = 4'(MAX_EXEC);

    phase_e     phase_q, phase_d;
    logic [3:0] exec_state_q, exec_state_d;
    logic [3:0] exec_cnt_q, exec_cnt_d;

    cls_e       cls;
    logic [CUL:0] sel_cw;
    logic [CUL:0] stall_cw;
    logic [3:0] sel_ns;
    logic [2:0] sel_k;
    logic       stall;
    logic       at_limit;

    // Only the class-select opcode bits are decoded here; the rest belong to sub-CUs.
    logic unused_ir;
    assign unused_ir = ^{IR[31:29], IR[24:0]};

    // Instruction class decode, first match wins.
    always_comb begin
        cls = ClsIll;
        if (IR[28:26] == 3'b100) begin
            cls = ClsImm;
        end else if (IR[28:26] == 3'b101) begin
            cls = ClsBr;
        end else if (IR[27:25] == 3'b101) begin
            cls = ClsReg;
        end else if (IR[27] && !IR[25]) begin
            cls = ClsMem;
        end
    end

    // Route the selected sub-CU's control word, k_mux and next state.
    always_comb begin
        sel_cw = NOP_CW;
        sel_ns = 4'b0000;
        sel_k  = 3'b000;
        case (cls)
            ClsImm: begin
                sel_cw = cw_imm;
                sel_ns = ns_imm;
                sel_k  = k_imm;
            end
            ClsReg: begin
                sel_cw = cw_reg;
                sel_ns = ns_reg;
                sel_k  = k_reg;
            end
            ClsMem: begin
                sel_cw = cw_mem;
                sel_ns = ns_mem;
                sel_k  = k_mem;
            end
            ClsBr: begin
                sel_cw = cw_br;
                sel_ns = ns_br;
                sel_k  = k_br;
            end
            default: begin
                sel_cw = NOP_CW;
                sel_ns = 4'b0000;
                sel_k  = 3'b000;
            end
        endcase
    end

    // Stalled word: keep the memory access presented, suppress every side effect.
    always_comb begin
        stall_cw        = sel_cw;
        stall_cw[15]    = 1'b0;
        stall_cw[10:8]  = 3'b000;
        stall_cw[1:0]   = 2'b00;
    end

    assign stall    = (phase_q == StExec) && (sel_cw[13:12] != 2'b00) && !mem_ready;
    assign at_limit = (exec_cnt_q == MaxCnt);

    // State register with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q      <= StFetch;
            exec_state_q <= 4'b0000;
            exec_cnt_q   <= 4'd0;
        end else begin
            phase_q      <= phase_d;
            exec_state_q <= exec_state_d;
            exec_cnt_q   <= exec_cnt_d;
        end
    end

    // Next-state logic for phase, exec_state and the watchdog counter.
    always_comb begin
        phase_d      = phase_q;
        exec_state_d = exec_state_q;
        exec_cnt_d   = exec_cnt_q;
        case (phase_q)
            StFetch: begin
                if (mem_ready) begin
                    phase_d      = StExec;
                    exec_state_d = 4'b0001;
                    exec_cnt_d   = 4'd1;
                end
            end
            StExec: begin
                if (!stall) begin
                    if (sel_ns == 4'b0000) begin
                        phase_d      = halt_req ? StHalt : StFetch;
                        exec_state_d = 4'b0000;
                        exec_cnt_d   = 4'd0;
                    end else if (at_limit) begin
                        // Watchdog wins over halt_req; halt is taken at the next boundary.
                        phase_d      = StFetch;
                        exec_state_d = 4'b0000;
                        exec_cnt_d   = 4'd0;
                    end else begin
                        exec_state_d = sel_ns;
                        exec_cnt_d   = exec_cnt_q + 4'd1;
                    end
                end
            end
            StHalt: begin
                if (!halt_req) begin
                    phase_d = StFetch;
                end
            end
            default: begin
                phase_d      = StFetch;
                exec_state_d = 4'b0000;
                exec_cnt_d   = 4'd0;
            end
        endcase
    end

    // Output decode from current phase, selected class and inputs.
    always_comb begin
        state       = 4'b0000;
        controlWord = '0;
        k_mux       = 3'b000;
        halted      = 1'b0;
        illegal     = 1'b0;
        timeout     = 1'b0;
        retire      = 1'b0;
        case (phase_q)
            StFetch: begin
                controlWord = FETCH_CW;
            end
            StExec: begin
                state       = exec_state_q;
                k_mux       = sel_k;
                controlWord = stall ? stall_cw : sel_cw;
                if (!stall) begin
                    if (sel_ns == 4'b0000) begin
                        retire  = 1'b1;
                        illegal = (cls == ClsIll);
                    end else if (at_limit) begin
                        timeout = 1'b1;
                    end
                end
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                controlWord = FETCH_CW;
            end
        endcase
    end

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed bench for cu_sequencer. Expected values are queued when each
// step is driven and popped at the negedge sample point.
module tb_cu_sequencer;

    localparam logic [35:0] FETCH_CW = 36'h000001220;
    localparam logic [35:0] NOP_CW   = 36'h000000001;

    localparam logic [35:0] CW_IMM   = 36'hA00008703;
    localparam logic [35:0] CW_REG   = 36'h512340004;
    localparam logic [35:0] CW_MEM   = 36'h300009703;
    localparam logic [35:0] CW_MEM_S = 36'h300001000;
    localparam logic [35:0] CW_BR    = 36'hC00000042;

    localparam logic [31:0] IR_IMM = 32'h91000421;
    localparam logic [31:0] IR_BR  = 32'h94000000;
    localparam logic [31:0] IR_REG = 32'h0A000000;
    localparam logic [31:0] IR_MEM = 32'h08000000;
    localparam logic [31:0] IR_ILL = 32'h00000000;

    logic        clock;
    logic        reset_n;
    logic [31:0] IR;
    logic        mem_ready;
    logic        halt_req;
    logic [35:0] cw_imm, cw_reg, cw_mem, cw_br;
    logic [3:0]  ns_imm, ns_reg, ns_mem, ns_br;
    logic [2:0]  k_imm, k_reg, k_mem, k_br;
    logic [3:0]  state;
    logic [35:0] controlWord;
    logic [2:0]  k_mux;
    logic        halted, illegal, timeout, retire;

    int checks   = 0;
    int failures = 0;

    string       tag_q[$];
    logic [35:0] exp_q[$];

    cu_sequencer #(
        .CUL      (35),
        .FETCH_CW (FETCH_CW),
        .NOP_CW   (NOP_CW),
        .MAX_EXEC (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .IR          (IR),
        .mem_ready   (mem_ready),
        .halt_req    (halt_req),
        .cw_imm      (cw_imm),
        .cw_reg      (cw_reg),
        .cw_mem      (cw_mem),
        .cw_br       (cw_br),
        .ns_imm      (ns_imm),
        .ns_reg      (ns_reg),
        .ns_mem      (ns_mem),
        .ns_br       (ns_br),
        .k_imm       (k_imm),
        .k_reg       (k_reg),
        .k_mem       (k_mem),
        .k_br        (k_br),
        .state       (state),
        .controlWord (controlWord),
        .k_mux       (k_mux),
        .halted      (halted),
        .illegal     (illegal),
        .timeout     (timeout),
        .retire      (retire)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_exp(input string tag, input logic [35:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [35:0] obs);
        string       t;
        logic [35:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty: observed %h with no expectation queued", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic exp_all(input string tag, input logic [3:0] st, input logic [35:0] cw,
                           input logic [2:0] k, input logic ret, input logic ill,
                           input logic to, input logic hl);
        push_exp({tag, "_state"}, 36'(st));
        push_exp({tag, "_cw"}, cw);
        push_exp({tag, "_kmux"}, 36'(k));
        push_exp({tag, "_retire"}, 36'(ret));
        push_exp({tag, "_illegal"}, 36'(ill));
        push_exp({tag, "_timeout"}, 36'(to));
        push_exp({tag, "_halted"}, 36'(hl));
    endtask

    task automatic obs_all();
        check(36'(state));
        check(controlWord);
        check(36'(k_mux));
        check(36'(retire));
        check(36'(illegal));
        check(36'(timeout));
        check(36'(halted));
    endtask

    // One clock cycle: queue expectations, sample at negedge, advance past posedge.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [35:0] cw,
                       input logic [2:0] k, input logic ret, input logic ill,
                       input logic to, input logic hl);
        exp_all(tag, st, cw, k, ret, ill, to, hl);
        @(negedge clock);
        obs_all();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        IR        = IR_ILL;
        mem_ready = 1'b0;
        halt_req  = 1'b0;
        cw_imm = CW_IMM; cw_reg = CW_REG; cw_mem = CW_MEM; cw_br = CW_BR;
        ns_imm = 4'd0;   ns_reg = 4'd0;   ns_mem = 4'd0;   ns_br = 4'd0;
        k_imm  = 3'd1;   k_reg  = 3'd2;   k_mem  = 3'd3;   k_br  = 3'd4;

        // Reset state
        exp_all("reset", 4'd0, FETCH_CW, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        obs_all();
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // FETCH waits for mem_ready
        mem_ready = 1'b0; IR = IR_IMM;
        cyc("fetch_wait", 4'd0, FETCH_CW, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ADDI: 2-cycle instruction
        mem_ready = 1'b1; ns_imm = 4'd0;
        cyc("addi_fetch", 4'd0, FETCH_CW, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("addi_exec", 4'd1, CW_IMM, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);

        // MOVK: two EXEC steps
        cyc("movk_fetch", 4'd0, FETCH_CW, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        ns_imm = 4'd2;
        cyc("movk_exec1", 4'd1, CW_IMM, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        ns_imm = 4'd0;
        cyc("movk_exec2", 4'd2, CW_IMM, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);

        // MEM with three stall cycles; halt_req during a stall is ignored
        IR = IR_MEM; ns_mem = 4'd0; mem_ready = 1'b1;
        cyc("mem_fetch", 4'd0, FETCH_CW, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b0;
            halt_req  = (i == 1);
            cyc($sformatf("mem_stall%0d", i), 4'd1, CW_MEM_S, 3'd3,
                1'b0, 1'b0, 1'b0, 1'b0);
        end
        halt_req = 1'b0; mem_ready = 1'b1;
        cyc("mem_done", 4'd1, CW_MEM, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);

        // Illegal opcode
        IR = IR_ILL;
        cyc("ill_fetch", 4'd0, FETCH_CW, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("ill_exec", 4'd1, NOP_CW, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        mem_ready = 1'b0;
        cyc("ill_after", 4'd0, FETCH_CW, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Watchdog: ns_reg stuck non-zero; halt_req on the timeout cycle loses
        IR = IR_REG; ns_reg = 4'd3; mem_ready = 1'b1;
        cyc("wd_fetch", 4'd0, FETCH_CW, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            halt_req = (i == 8);
            cyc($sformatf("wd_exec%0d", i), (i == 1) ? 4'd1 : 4'd3, CW_REG, 3'd2,
                1'b0, 1'b0, (i == 8), 1'b0);
        end
        halt_req = 1'b0; mem_ready = 1'b0;
        cyc("wd_after", 4'd0, FETCH_CW, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Halt at instruction boundary; halt_req during FETCH has no effect
        IR = IR_BR; ns_br = 4'd0; mem_ready = 1'b1; halt_req = 1'b1;
        cyc("halt_fetch", 4'd0, FETCH_CW, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("halt_exec", 4'd1, CW_BR, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("halt_hold", 4'd0, 36'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        halt_req = 1'b0; mem_ready = 1'b0;
        cyc("halt_leave", 4'd0, 36'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("halt_after", 4'd0, FETCH_CW, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-EXEC
        IR = IR_IMM; mem_ready = 1'b1;
        cyc("rst_fetch", 4'd0, FETCH_CW, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        ns_imm = 4'd2;
        exp_all("rst_exec", 4'd1, CW_IMM, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        obs_all();
        #1;
        reset_n = 1'b0;
        exp_all("rst_async", 4'd0, FETCH_CW, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        obs_all();
        @(posedge clock);
        #1;
        reset_n = 1'b1; mem_ready = 1'b0; ns_imm = 4'd0;
        cyc("rst_after", 4'd0, FETCH_CW, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
